change_dispenser: RTL and testbench

- Vending-machine payout block. It sits on the opposite side of the coin-accumulation path.
- On a purchase request it compares accumulated credit against item price, then either rejects the request or vends.
- When vending, it returns change = credit - price as a sequence of coins, chosen greedily with a valid/ack handshake toward the coin-ejector mechanism.
- Coin denominations are 5, 2 and 1 units.

---
 rtl/change_dispenser.sv | 173 +++++++++++++++++
 tb/tb_change_dispenser.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Vending payout controller: checks credit against price, then returns the change
// greedily as 5/2/1 coins using a valid/ack handshake to the coin ejector.
module change_dispenser #(
    parameter int WIDTH    = 4,
    parameter int COIN_HI  = 5,
    parameter int COIN_MID = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_credit,
    input  logic [WIDTH-1:0] i_price,
    input  logic             i_coin_ack,
    output logic             o_ready,
    output logic             o_vend,
    output logic             o_reject,
    output logic             o_coin_valid,
    output logic [1:0]       o_coin_sel,
    output logic [WIDTH-1:0] o_remaining,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DISPENSE,
        DONE
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_ONE  = 2'b01;
    localparam logic [1:0] SEL_MID  = 2'b10;
    localparam logic [1:0] SEL_HI   = 2'b11;

    localparam logic [WIDTH-1:0] HI_VAL  = WIDTH'(COIN_HI);
    localparam logic [WIDTH-1:0] MID_VAL = WIDTH'(COIN_MID);
    localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] credit_q, credit_d;
    logic [WIDTH-1:0] price_q, price_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             ready_q, ready_d;
    logic             vend_q, vend_d;
    logic             reject_q, reject_d;
    logic             coin_valid_q, coin_valid_d;
    logic [1:0]       coin_sel_q, coin_sel_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] after_coin;

    function automatic logic [1:0] greedy(input logic [WIDTH-1:0] r);
        if (r >= HI_VAL)
            return SEL_HI;
        else if (r >= MID_VAL)
            return SEL_MID;
        else
            return SEL_ONE;
    endfunction

    function automatic logic [WIDTH-1:0] coin_value(input logic [1:0] sel);
        case (sel)
            SEL_HI:  return HI_VAL;
            SEL_MID: return MID_VAL;
            SEL_ONE: return ONE_VAL;
            default: return '0;
        endcase
    endfunction

    assign diff       = credit_q - price_q;
    assign after_coin = remaining_q - coin_value(coin_sel_q);

    // Every output is a flop; the next-state logic computes what each output
    // shows in the cycle after the current edge.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        price_d      = price_q;
        remaining_d  = remaining_q;
        coin_valid_d = coin_valid_q;
        coin_sel_d   = coin_sel_q;
        vend_d       = 1'b0;
        reject_d     = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    credit_d = i_credit;
                    price_d  = i_price;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (credit_q < price_q) begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    vend_d      = 1'b1;
                    remaining_d = diff;
                    if (diff == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d      = DISPENSE;
                        coin_valid_d = 1'b1;
                        coin_sel_d   = greedy(diff);
                    end
                end
            end
            DISPENSE: begin
                if (i_coin_ack && coin_valid_q) begin
                    remaining_d = after_coin;
                    if (after_coin == '0) begin
                        state_d      = DONE;
                        coin_valid_d = 1'b0;
                        coin_sel_d   = SEL_NONE;
                    end else begin
                        coin_sel_d = greedy(after_coin);
                    end
                end
            end
            DONE: begin
                done_d       = 1'b1;
                coin_valid_d = 1'b0;
                coin_sel_d   = SEL_NONE;
                state_d      = IDLE;
            end
            default: begin
                state_d      = IDLE;
                coin_valid_d = 1'b0;
                coin_sel_d   = SEL_NONE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            price_q      <= '0;
            remaining_q  <= '0;
            ready_q      <= 1'b1;
            vend_q       <= 1'b0;
            reject_q     <= 1'b0;
            coin_valid_q <= 1'b0;
            coin_sel_q   <= SEL_NONE;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            price_q      <= price_d;
            remaining_q  <= remaining_d;
            ready_q      <= ready_d;
            vend_q       <= vend_d;
            reject_q     <= reject_d;
            coin_valid_q <= coin_valid_d;
            coin_sel_q   <= coin_sel_d;
            done_q       <= done_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_vend       = vend_q;
    assign o_reject     = reject_q;
    assign o_coin_valid = coin_valid_q;
    assign o_coin_sel   = coin_sel_q;
    assign o_remaining  = remaining_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: drives purchases and compares the full
// output vector against hand-computed values after every clock edge.
module tb_change_dispenser;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [3:0] i_credit;
    logic [3:0] i_price;
    logic       i_coin_ack;
    logic       o_ready;
    logic       o_vend;
    logic       o_reject;
    logic       o_coin_valid;
    logic [1:0] o_coin_sel;
    logic [3:0] o_remaining;
    logic       o_done;

    int checkCount = 0;
    int errorCount = 0;

    change_dispenser #(.WIDTH(4), .COIN_HI(5), .COIN_MID(2)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_credit     (i_credit),
        .i_price      (i_price),
        .i_coin_ack   (i_coin_ack),
        .o_ready      (o_ready),
        .o_vend       (o_vend),
        .o_reject     (o_reject),
        .o_coin_valid (o_coin_valid),
        .o_coin_sel   (o_coin_sel),
        .o_remaining  (o_remaining),
        .o_done       (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Output vector layout: ready, vend, reject, valid, sel[1:0], remaining[3:0], done
    function automatic logic [10:0] expOut(input logic r, input logic v, input logic j,
                                           input logic c, input logic [1:0] s,
                                           input logic [3:0] rem, input logic d);
        return {r, v, j, c, s, rem, d};
    endfunction

    function automatic logic [10:0] obsOut();
        return {o_ready, o_vend, o_reject, o_coin_valid, o_coin_sel, o_remaining, o_done};
    endfunction

    task automatic checkOutput(input string tag, input logic [10:0] observed,
                               input logic [10:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%b expected=%b (rdy,vend,rej,val,sel,rem,done)",
                     tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] credit, input logic [3:0] price);
        i_start  = 1'b1;
        i_credit = credit;
        i_price  = price;
        tick();
        i_start  = 1'b0;
    endtask

    initial begin
        i_rst      = 1'b0;
        i_start    = 1'b0;
        i_credit   = '0;
        i_price    = '0;
        i_coin_ack = 1'b0;

        // 1: reset asserted between edges takes effect immediately
        #2 i_rst = 1'b1;
        #1 checkOutput("rst_async", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));
        tick();
        i_rst = 1'b0;
        tick();
        checkOutput("rst_idle", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));

        // 2: 13 - 4 = 9 -> coins 5,2,2 with back-to-back acks
        applyStimulus(4'd13, 4'd4);
        checkOutput("t2_check", obsOut(), expOut(0, 0, 0, 0, 2'b00, 4'd0, 0));
        tick();
        checkOutput("t2_vend", obsOut(), expOut(0, 1, 0, 1, 2'b11, 4'd9, 0));
        i_coin_ack = 1'b1;
        tick();
        checkOutput("t2_coin2", obsOut(), expOut(0, 0, 0, 1, 2'b10, 4'd4, 0));
        tick();
        checkOutput("t2_coin3", obsOut(), expOut(0, 0, 0, 1, 2'b10, 4'd2, 0));
        tick();
        checkOutput("t2_empty", obsOut(), expOut(0, 0, 0, 0, 2'b00, 4'd0, 0));
        i_coin_ack = 1'b0;
        tick();
        checkOutput("t2_done", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 1));
        tick();
        checkOutput("t2_idle", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));

        // 3: insufficient credit
        applyStimulus(4'd3, 4'd7);
        checkOutput("t3_check", obsOut(), expOut(0, 0, 0, 0, 2'b00, 4'd0, 0));
        tick();
        checkOutput("t3_reject", obsOut(), expOut(1, 0, 1, 0, 2'b00, 4'd0, 0));
        tick();
        checkOutput("t3_idle", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));

        // 4: exact change, no coins
        applyStimulus(4'd6, 4'd6);
        checkOutput("t4_check", obsOut(), expOut(0, 0, 0, 0, 2'b00, 4'd0, 0));
        tick();
        checkOutput("t4_vend", obsOut(), expOut(0, 1, 0, 0, 2'b00, 4'd0, 0));
        tick();
        checkOutput("t4_done", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 1));
        tick();
        checkOutput("t4_idle", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));

        // 5: price 0, slow acks, stray start during dispense
        applyStimulus(4'd15, 4'd0);
        tick();
        checkOutput("t5_vend", obsOut(), expOut(0, 1, 0, 1, 2'b11, 4'd15, 0));
        for (int k = 0; k < 3; k++) begin
            for (int h = 0; h < 3; h++) begin
                if (k == 0 && h == 0) begin
                    i_start  = 1'b1;
                    i_credit = 4'd2;
                    i_price  = 4'd1;
                end
                tick();
                i_start = 1'b0;
                checkOutput($sformatf("t5_hold%0d_%0d", k, h), obsOut(),
                            expOut(0, 0, 0, 1, 2'b11, 4'(15 - 5 * k), 0));
            end
            i_coin_ack = 1'b1;
            tick();
            i_coin_ack = 1'b0;
            checkOutput($sformatf("t5_ack%0d", k), obsOut(),
                        expOut(0, 0, 0, (k < 2), (k < 2) ? 2'b11 : 2'b00,
                               4'(15 - 5 * (k + 1)), 0));
        end
        tick();
        checkOutput("t5_done", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 1));
        tick();
        checkOutput("t5_idle", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));

        // 6: reset aborts dispense mid-transaction, then a single 1-unit coin
        applyStimulus(4'd8, 4'd0);
        tick();
        checkOutput("t6_vend", obsOut(), expOut(0, 1, 0, 1, 2'b11, 4'd8, 0));
        i_coin_ack = 1'b1;
        tick();
        i_coin_ack = 1'b0;
        checkOutput("t6_ack", obsOut(), expOut(0, 0, 0, 1, 2'b10, 4'd3, 0));
        #2 i_rst = 1'b1;
        #1 checkOutput("t6_rst_async", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));
        tick();
        i_rst = 1'b0;
        checkOutput("t6_rst_hold", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));
        tick();
        checkOutput("t6_no_done", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));
        applyStimulus(4'd1, 4'd0);
        tick();
        checkOutput("t6_vend1", obsOut(), expOut(0, 1, 0, 1, 2'b01, 4'd1, 0));
        i_coin_ack = 1'b1;
        tick();
        i_coin_ack = 1'b0;
        checkOutput("t6_empty", obsOut(), expOut(0, 0, 0, 0, 2'b00, 4'd0, 0));
        tick();
        checkOutput("t6_done", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 1));
        tick();
        checkOutput("t6_idle", obsOut(), expOut(1, 0, 0, 0, 2'b00, 4'd0, 0));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
